// File: rtl/ctrl_sequencer_if.sv
// Bus between the instruction register / datapath and the control sequencer.
// master = datapath/testbench side, slave = the sequencer itself.
interface ctrl_sequencer_if #(
  parameter int NREG = 8,
  parameter int ALUW = 4
);
  logic            Run;
  logic [9:0]      INSTR;
  logic            IR_EN;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            ENA;
  logic            ENG;
  logic            GOUT;
  logic            EXTRN;
  logic            IMM_OUT;
  logic [9:0]      IMM;
  logic [ALUW-1:0] ALU_OP;
  logic [1:0]      TS;
  logic            Done;

  modport master (
    output Run, INSTR,
    input  IR_EN, Rin, Rout, ENA, ENG, GOUT, EXTRN, IMM_OUT, IMM, ALU_OP, TS, Done
  );

  modport slave (
    input  Run, INSTR,
    output IR_EN, Rin, Rout, ENA, ENG, GOUT, EXTRN, IMM_OUT, IMM, ALU_OP, TS, Done
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Timestep sequencer: fetches via IR_EN in T0, then decodes the held
// instruction over T1..T3 into one-hot register/ALU/bus controls.
module ctrl_sequencer #(
  parameter int NREG = 8,
  parameter int ALUW = 4
) (
  input  logic             CLKb,
  input  logic             Clrb,
  ctrl_sequencer_if.slave  bus
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]      r_ts;
  logic [1:0]      w_ts_nxt;
  logic [3:0]      w_op;
  logic [2:0]      w_x;
  logic [2:0]      w_y;
  logic [NREG-1:0] w_rx;
  logic [NREG-1:0] w_ry;

  logic            w_is_load;
  logic            w_is_mov;
  logic            w_is_bin;
  logic            w_is_imm;
  logic            w_is_not;
  logic [1:0]      w_last;
  logic [ALUW-1:0] w_alu;

  logic            w_ir_en;
  logic [NREG-1:0] w_rin;
  logic [NREG-1:0] w_rout;
  logic            w_ena;
  logic            w_eng;
  logic            w_gout;
  logic            w_extrn;
  logic            w_imm_out;
  logic [ALUW-1:0] w_alu_op;
  logic            w_done;

  assign w_op = bus.INSTR[9:6];
  assign w_x  = bus.INSTR[5:3];
  assign w_y  = bus.INSTR[2:0];
  assign w_rx = NREG'(1) << w_x;
  assign w_ry = NREG'(1) << w_y;

  // Instruction classes; anything not matched is a reserved single-step NOP.
  always_comb begin
    w_is_load = (w_op == 4'b0000);
    w_is_mov  = (w_op == 4'b0001);
    w_is_not  = (w_op == 4'b0100);
    w_is_imm  = (w_op == 4'b1000) || (w_op == 4'b1001);
    w_is_bin  = w_is_imm || (w_op == 4'b0010) || (w_op == 4'b0011) ||
                (w_op == 4'b0101) || (w_op == 4'b0110) || (w_op == 4'b0111);
  end

  always_comb begin
    w_last = T1;
    if (w_is_bin)      w_last = T3;
    else if (w_is_not) w_last = T2;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'b0010, 4'b1000: w_alu = ALUW'(0);
      4'b0011, 4'b1001: w_alu = ALUW'(1);
      4'b0100:          w_alu = ALUW'(2);
      4'b0101:          w_alu = ALUW'(3);
      4'b0110:          w_alu = ALUW'(4);
      4'b0111:          w_alu = ALUW'(5);
      default:          w_alu = '0;
    endcase
  end

  always_comb begin
    w_ir_en   = 1'b0;
    w_rin     = '0;
    w_rout    = '0;
    w_ena     = 1'b0;
    w_eng     = 1'b0;
    w_gout    = 1'b0;
    w_extrn   = 1'b0;
    w_imm_out = 1'b0;
    w_alu_op  = '0;
    w_done    = 1'b0;
    case (r_ts)
      T0: w_ir_en = bus.Run;
      T1: begin
        if (w_is_load) begin
          w_extrn = 1'b1;
          w_rin   = w_rx;
          w_done  = 1'b1;
        end else if (w_is_mov) begin
          w_rout = w_ry;
          w_rin  = w_rx;
          w_done = 1'b1;
        end else if (w_is_bin) begin
          w_rout = w_rx;
          w_ena  = 1'b1;
        end else if (w_is_not) begin
          w_rout   = w_ry;
          w_eng    = 1'b1;
          w_alu_op = w_alu;
        end else begin
          w_done = 1'b1;
        end
      end
      T2: begin
        if (w_is_bin) begin
          if (w_is_imm) w_imm_out = 1'b1;
          else          w_rout    = w_ry;
          w_eng    = 1'b1;
          w_alu_op = w_alu;
        end else if (w_is_not) begin
          w_gout = 1'b1;
          w_rin  = w_rx;
          w_done = 1'b1;
        end
      end
      T3: begin
        if (w_is_bin) begin
          w_gout = 1'b1;
          w_rin  = w_rx;
          w_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A step past the instruction's last one can only come from a mid-flight
  // INSTR change; fall back to T0 rather than walking into T3.
  always_comb begin
    w_ts_nxt = T0;
    if (r_ts == T0)        w_ts_nxt = bus.Run ? T1 : T0;
    else if (r_ts < w_last) w_ts_nxt = r_ts + 2'd1;
  end

  always_ff @(negedge CLKb or negedge Clrb) begin
    if (!Clrb) r_ts <= T0;
    else       r_ts <= w_ts_nxt;
  end

  assign bus.IR_EN   = w_ir_en;
  assign bus.Rin     = w_rin;
  assign bus.Rout    = w_rout;
  assign bus.ENA     = w_ena;
  assign bus.ENG     = w_eng;
  assign bus.GOUT    = w_gout;
  assign bus.EXTRN   = w_extrn;
  assign bus.IMM_OUT = w_imm_out;
  assign bus.ALU_OP  = w_alu_op;
  assign bus.TS      = r_ts;
  assign bus.Done    = w_done;
  // Immediate field is held at 0 while in reset so only IR_EN can be live.
  assign bus.IMM     = Clrb ? {7'b0, w_y} : 10'd0;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios plus random instruction streams
// checked against a per-instruction micro-step scoreboard.
module tb_ctrl_sequencer;

  logic CLKb = 1'b1;
  logic Clrb = 1'b0;
  always #5 CLKb = ~CLKb;

  ctrl_sequencer_if #(.NREG(8), .ALUW(4)) bus ();
  ctrl_sequencer #(.NREG(8), .ALUW(4)) dut (.CLKb(CLKb), .Clrb(Clrb), .bus(bus.slave));

  typedef struct packed {
    logic       ir_en;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ena;
    logic       eng;
    logic       gout;
    logic       extrn;
    logic       imm_out;
    logic [9:0] imm;
    logic [3:0] alu;
    logic [1:0] ts;
    logic       done;
  } rec_t;

  rec_t       q[$];
  rec_t       exp_r, act_r;
  logic [9:0] cur_instr;
  int         n_total = 0;
  int         n_fail  = 0;

  // Expected T1..Tn cycles of one instruction, from the opcode table.
  function automatic void build(input logic [9:0] ins);
    logic [3:0] op = ins[9:6];
    logic [7:0] rx = 8'd1 << ins[5:3];
    logic [7:0] ry = 8'd1 << ins[2:0];
    logic [3:0] alu;
    rec_t b, r1, r2, r3;
    b = '0;
    b.imm = {7'b0, ins[2:0]};
    case (op)
      4'd2, 4'd8: alu = 4'd0;
      4'd3, 4'd9: alu = 4'd1;
      4'd4:       alu = 4'd2;
      4'd5:       alu = 4'd3;
      4'd6:       alu = 4'd4;
      4'd7:       alu = 4'd5;
      default:    alu = 4'd0;
    endcase
    r1 = b; r1.ts = 2'd1;
    r2 = b; r2.ts = 2'd2;
    r3 = b; r3.ts = 2'd3;
    if (op == 4'd0) begin
      r1.extrn = 1; r1.rin = rx; r1.done = 1;
      q.push_back(r1);
    end else if (op == 4'd1) begin
      r1.rout = ry; r1.rin = rx; r1.done = 1;
      q.push_back(r1);
    end else if (op == 4'd4) begin
      r1.rout = ry; r1.eng = 1; r1.alu = alu;
      r2.gout = 1; r2.rin = rx; r2.done = 1;
      q.push_back(r1); q.push_back(r2);
    end else if (op <= 4'd9) begin
      r1.rout = rx; r1.ena = 1;
      if (op >= 4'd8) r2.imm_out = 1; else r2.rout = ry;
      r2.eng = 1; r2.alu = alu;
      r3.gout = 1; r3.rin = rx; r3.done = 1;
      q.push_back(r1); q.push_back(r2); q.push_back(r3);
    end else begin
      r1.done = 1;
      q.push_back(r1);
    end
  endfunction

  function automatic rec_t sample();
    rec_t a;
    a.ir_en = bus.IR_EN;   a.rin = bus.Rin;     a.rout = bus.Rout;
    a.ena = bus.ENA;       a.eng = bus.ENG;     a.gout = bus.GOUT;
    a.extrn = bus.EXTRN;   a.imm_out = bus.IMM_OUT; a.imm = bus.IMM;
    a.alu = bus.ALU_OP;    a.ts = bus.TS;       a.done = bus.Done;
    return a;
  endfunction

  // Drive one cycle's inputs; INSTR only changes in T0 (IR is held otherwise).
  task automatic step(input logic run, input logic [9:0] instr);
    bit t0 = (q.size() == 0);
    if (t0) begin
      cur_instr = instr;
      exp_r = '0;
      exp_r.ir_en = run;
      exp_r.imm = {7'b0, instr[2:0]};
    end else begin
      exp_r = q.pop_front();
    end
    bus.Run = run;
    bus.INSTR = cur_instr;
    #1;
    act_r = sample();
    if (t0 && run) build(cur_instr);
  endtask

  task automatic tick();
    @(negedge CLKb);
    #1;
  endtask

  task automatic test_reset();
    bus.Run = 1'b0; bus.INSTR = 10'd0;
    #2;
    n_total++;
    if (sample() !== rec_t'(0)) begin
      n_fail++; $display("FAIL reset_idle got=%h want=0", sample());
    end
    bus.Run = 1'b1; #1;
    n_total++;
    if (bus.IR_EN !== 1'b1 || bus.TS !== 2'd0) begin
      n_fail++; $display("FAIL reset_ir_en got ir_en=%b ts=%0d want ir_en=1 ts=0", bus.IR_EN, bus.TS);
    end
    bus.Run = 1'b0;
    tick();
    Clrb = 1'b1;
  endtask

  task automatic test_abort();
    step(1, 10'b0010_010_110); tick();
    step(1, 10'b0010_010_110); tick();
    step(0, 10'b0010_010_110);
    n_total++;
    if (act_r.ts !== 2'd2 || act_r !== exp_r) begin
      n_fail++; $display("FAIL abort_pre got=%h want=%h", act_r, exp_r);
    end
    bus.Run = 1'b1;
    Clrb = 1'b0; #1;
    exp_r = '0; exp_r.ir_en = 1'b1;
    n_total++;
    if (sample() !== exp_r) begin
      n_fail++; $display("FAIL abort_clr got=%h want=%h", sample(), exp_r);
    end
    q.delete();
    tick();
    n_total++;
    if (bus.TS !== 2'd0) begin
      n_fail++; $display("FAIL abort_hold got ts=%0d want 0", bus.TS);
    end
    Clrb = 1'b1;
    step(0, 10'd0); tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.ts !== 2'd0 || act_r.ir_en !== 1'b0 || act_r !== exp_r) begin
      n_fail++; $display("FAIL idle_after_clr got=%h want=%h", act_r, exp_r);
    end
    tick();
  endtask

  task automatic test_load();
    step(1, 10'b0000_101_000);
    n_total++;
    if (act_r.ir_en !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL load_t0 got=%h want=%h", act_r, exp_r);
    end
    tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.extrn !== 1'b1 || act_r.rin !== 8'h20 || act_r.done !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL load_t1 got=%h want=%h", act_r, exp_r);
    end
    tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.ts !== 2'd0) begin
      n_fail++; $display("FAIL load_back got ts=%0d want 0", act_r.ts);
    end
    tick();
  endtask

  task automatic test_add();
    step(1, 10'b0010_010_110); tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.rout !== 8'h04 || act_r.ena !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL add_t1 got=%h want=%h", act_r, exp_r);
    end
    tick(); step(0, 10'd0);
    n_total++;
    if (act_r.rout !== 8'h40 || act_r.eng !== 1'b1 || act_r.alu !== 4'd0 || act_r !== exp_r) begin
      n_fail++; $display("FAIL add_t2 got=%h want=%h", act_r, exp_r);
    end
    tick(); step(0, 10'd0);
    n_total++;
    if (act_r.gout !== 1'b1 || act_r.rin !== 8'h04 || act_r.done !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL add_t3 got=%h want=%h", act_r, exp_r);
    end
    tick();
  endtask

  task automatic test_subi();
    step(1, 10'b1001_001_101); tick();
    step(0, 10'd0); tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.imm_out !== 1'b1 || act_r.imm !== 10'd5 || act_r.alu !== 4'd1 ||
        act_r.rout !== 8'h00 || act_r !== exp_r) begin
      n_fail++; $display("FAIL subi_t2 got=%h want=%h", act_r, exp_r);
    end
    tick(); step(0, 10'd0);
    n_total++;
    if (act_r.rin !== 8'h02 || act_r.done !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL subi_t3 got=%h want=%h", act_r, exp_r);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      step(1, 10'b0100_000_111);
      n_total++;
      if (act_r !== exp_r || act_r.ts !== 2'(c)) begin
        n_fail++; $display("FAIL not_c%0d got=%h want=%h", c, act_r, exp_r);
      end
      tick();
    end
    step(1, 10'b0001_100_000);
    n_total++;
    if (act_r.ts !== 2'd0 || act_r.ir_en !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL mov_t0 got=%h want=%h", act_r, exp_r);
    end
    tick(); step(0, 10'd0);
    n_total++;
    if (act_r.rout !== 8'h01 || act_r.rin !== 8'h10 || act_r.done !== 1'b1 || act_r !== exp_r) begin
      n_fail++; $display("FAIL mov_t1 got=%h want=%h", act_r, exp_r);
    end
    tick();
  endtask

  task automatic test_reserved();
    step(1, 10'b1111_000_000); tick();
    step(0, 10'd0);
    n_total++;
    if (act_r.done !== 1'b1 || act_r.rin !== 8'h00 || act_r.rout !== 8'h00 ||
        act_r.eng !== 1'b0 || act_r !== exp_r) begin
      n_fail++; $display("FAIL rsv_t1 got=%h want=%h", act_r, exp_r);
    end
    tick(); step(0, 10'd0);
    n_total++;
    if (act_r.ts !== 2'd0) begin
      n_fail++; $display("FAIL rsv_back got ts=%0d want 0", act_r.ts);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
      n_total++;
      if (act_r !== exp_r) begin
        n_fail++; $display("FAIL rand_c%0d got=%h want=%h", c, act_r, exp_r);
      end
      tick();
    end
  endtask

  initial begin
    bus.Run = 1'b0;
    bus.INSTR = 10'd0;
    cur_instr = 10'd0;
    test_reset();
    test_abort();
    test_load();
    test_add();
    test_subi();
    test_back_to_back();
    test_reserved();
    test_random();
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
